// File: rtl/cdb_arbiter_if.sv
// Common Data Bus arbiter bus: functional-unit requests, grants, flush and
// the registered CDB broadcast. The arbiter takes the slave side; the
// functional units, ROB and consumers take the master side.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      flush;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;

  modport slave (
    input  req_valid, req_tag, req_data, flush,
    output req_ready, cdb_valid, cdb_tag, cdb_data
  );

  modport master (
    output req_valid, req_tag, req_data, flush,
    input  req_ready, cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant of one completed result per
// cycle onto a registered CDB broadcast; flush squashes the grant and the
// next broadcast. Optional performance counters are enabled by defining
// CDB_ARB_PERF_EN.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  cdb_arbiter_if.slave   cdb
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [31:0]    perf_busy_cnt,
  output logic [31:0]    perf_conflict_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned NUM_REQ_M1 = NUM_REQ - 1;
  localparam logic [PTR_W:0]   NUM_REQ_W = NUM_REQ[PTR_W:0];
  localparam logic [PTR_W-1:0] PTR_MAX   = NUM_REQ_M1[PTR_W-1:0];

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   win;
  logic               found;
  logic [NUM_REQ-1:0] grant;
  logic               xfer;
  logic [TAG_W-1:0]   tags  [NUM_REQ];
  logic [DATA_W-1:0]  datas [NUM_REQ];

  // Unpack the flat per-unit tag/data buses into indexable arrays.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      tags[i]  = cdb.req_tag[i*TAG_W +: TAG_W];
      datas[i] = cdb.req_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search from ptr upward with wrap; first valid unit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    grant = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      logic [PTR_W:0]   sum;
      logic [PTR_W-1:0] idx;
      sum = {1'b0, ptr} + k[PTR_W:0];
      if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
      idx = sum[PTR_W-1:0];
      if (!found && cdb.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found && !cdb.flush && rst_n) grant[win] = 1'b1;
  end

  assign cdb.req_ready = grant;
  assign xfer          = |grant;

  // Broadcast register and pointer advance; flush is already folded into grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      cdb.cdb_valid <= 1'b0;
      cdb.cdb_tag   <= '0;
      cdb.cdb_data  <= '0;
    end else begin
      cdb.cdb_valid <= xfer;
      if (xfer) begin
        cdb.cdb_tag  <= tags[win];
        cdb.cdb_data <= datas[win];
        ptr          <= (win == PTR_MAX) ? '0 : win + 1'b1;
      end
    end
  end

`ifdef CDB_ARB_PERF_EN
  logic conflict;
  assign conflict = ((cdb.req_valid & (cdb.req_valid - 1'b1)) != '0) && !cdb.flush;

  // Transfer and contention counters, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cnt     <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (xfer)     perf_busy_cnt     <= perf_busy_cnt + 32'd1;
      if (conflict) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (NUM_REQ=4, TAG_W=5, DATA_W=32).
module tb_cdb_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TW = 5;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst_n;

  cdb_arbiter_if #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) bus ();

`ifdef CDB_ARB_PERF_EN
  logic [31:0] perf_busy_cnt;
  logic [31:0] perf_conflict_cnt;
`endif

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cdb   (bus.slave)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_busy_cnt     (perf_busy_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [N-1:0] v;
    logic         f;
    logic [N-1:0] rdy;
  } vec_t;

  exp_t          sbq[$];
  vec_t          tbl[17];
  logic [TW-1:0] tag_in  [N];
  logic [DW-1:0] data_in [N];
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic f);
    bus.req_valid = v;
    bus.flush     = f;
    for (int i = 0; i < N; i++) begin
      bus.req_tag[i*TW +: TW]  = tag_in[i];
      bus.req_data[i*DW +: DW] = data_in[i];
    end
  endtask

  task automatic check_cdb(input string nm);
    exp_t e;
    if (sbq.size() > 0) e = sbq.pop_front();
    else begin
      e.v = 1'b0; e.tag = '0; e.data = '0;
    end
    chk({nm, "/cdb_valid"}, 64'(bus.cdb_valid), 64'(e.v));
    if (e.v) begin
      chk({nm, "/cdb_tag"},  64'(bus.cdb_tag),  64'(e.tag));
      chk({nm, "/cdb_data"}, 64'(bus.cdb_data), 64'(e.data));
    end
  endtask

  // One cycle: drive at posedge+1, check the broadcast of the previous
  // transfer and this cycle's grant at negedge, queue this grant's result.
  task automatic step(input logic [N-1:0] v, input logic f, input logic [N-1:0] er,
                      input string nm);
    exp_t e;
    drive(v, f);
    @(negedge clk);
    check_cdb(nm);
    chk({nm, "/req_ready"}, 64'(bus.req_ready), 64'(er));
    e.v = |er; e.tag = '0; e.data = '0;
    for (int i = 0; i < N; i++)
      if (er[i]) begin
        e.tag  = tag_in[i];
        e.data = data_in[i];
      end
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      tag_in[i]  = 5'(i + 1);
      data_in[i] = 32'h1111_1111 * (i + 1);
    end
    // ptr walk: 0 ->1 ->2 ->3 ->0 ->1, idle, lone unit 0, 3/0 pair,
    // flush (ptr stays 1), then wrap checks.
    tbl[0]  = '{4'b1111, 1'b0, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b0, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0001};
    tbl[5]  = '{4'b0000, 1'b0, 4'b0000};
    tbl[6]  = '{4'b0001, 1'b0, 4'b0001};
    tbl[7]  = '{4'b0001, 1'b0, 4'b0001};
    tbl[8]  = '{4'b1001, 1'b0, 4'b1000};
    tbl[9]  = '{4'b1001, 1'b0, 4'b0001};
    tbl[10] = '{4'b0011, 1'b1, 4'b0000};
    tbl[11] = '{4'b0011, 1'b0, 4'b0010};
    tbl[12] = '{4'b0011, 1'b0, 4'b0001};
    tbl[13] = '{4'b1100, 1'b0, 4'b0100};
    tbl[14] = '{4'b1100, 1'b0, 4'b1000};
    tbl[15] = '{4'b0000, 1'b0, 4'b0000};
    tbl[16] = '{4'b0000, 1'b0, 4'b0000};

    // Reset with every unit requesting.
    rst_n = 1'b0;
    drive(4'b1111, 1'b0);
    #12;
    chk("reset/req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset/cdb_valid", 64'(bus.cdb_valid), 64'd0);
    chk("reset/cdb_tag",   64'(bus.cdb_tag),   64'd0);
    chk("reset/cdb_data",  64'(bus.cdb_data),  64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int r = 0; r < 17; r++)
      step(tbl[r].v, tbl[r].f, tbl[r].rdy, $sformatf("row%0d", r));

    // Single requester (ptr = 0).
    tag_in[2]  = 5'd5;
    data_in[2] = 32'hDEAD_BEEF;
    step(4'b0100, 1'b0, 4'b0100, "single/grant");
    step(4'b0000, 1'b0, 4'b0000, "single/bcast");
    step(4'b0000, 1'b0, 4'b0000, "single/idle");

    // Stall hold: bring ptr back to 0, then units 1 and 3 contend.
    step(4'b1000, 1'b0, 4'b1000, "stall/align");
    tag_in[1] = 5'd7;
    tag_in[3] = 5'd9;
    step(4'b1010, 1'b0, 4'b0010, "stall/first");
    step(4'b1000, 1'b0, 4'b1000, "stall/held");
    step(4'b0000, 1'b0, 4'b0000, "stall/bcast9");
    step(4'b0000, 1'b0, 4'b0000, "stall/idle");

    // Asynchronous reset while a broadcast is live.
    step(4'b0001, 1'b0, 4'b0001, "arst/grant");
    check_cdb("arst/live");
    rst_n = 1'b0;
    drive(4'b1111, 1'b0);
    #1;
    chk("arst/cdb_valid", 64'(bus.cdb_valid), 64'd0);
    chk("arst/cdb_tag",   64'(bus.cdb_tag),   64'd0);
    chk("arst/cdb_data",  64'(bus.cdb_data),  64'd0);
    chk("arst/req_ready", 64'(bus.req_ready), 64'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef CDB_ARB_PERF_EN
    for (int c = 0; c < 10; c++)
      step(4'b0111, 1'b0, 4'b0001 << (c % 3), $sformatf("perf%0d", c));
    chk("perf/busy",     64'(perf_busy_cnt),     64'd10);
    chk("perf/conflict", 64'(perf_conflict_cnt), 64'd10);
    step(4'b0000, 1'b0, 4'b0000, "perf/drain");
    rst_n = 1'b0;
    #1;
    chk("perf/busy_rst",     64'(perf_busy_cnt),     64'd0);
    chk("perf/conflict_rst", 64'(perf_conflict_cnt), 64'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`endif

    step(4'b1111, 1'b0, 4'b0001, "post_rst/grant0");
    step(4'b0000, 1'b0, 4'b0000, "post_rst/bcast");
    step(4'b0000, 1'b0, 4'b0000, "post_rst/idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter for the Tomasulo core. It accepts completed results (ROB tag plus value) from up to `NUM_REQ` functional units and grants one per cycle using round-robin. It drives the registered CDB broadcast (`cdb_valid`/`cdb_tag`/`cdb_data`) that is consumed by the RAT, reservation stations and ROB. On `flush` it squashes both the in-flight broadcast and any grant for that cycle.

## Interface
- `NUM_REQ`, 4: number of requesting functional units (2..8).
- `TAG_W`, 5: ROB tag width, matching the RAT tag width.
- `DATA_W`, 32: result width.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  NUM_REQ  per-unit result valid.
- `req_tag`  in  NUM_REQ*TAG_W  per-unit ROB tag; unit i occupies bits [i*TAG_W +: TAG_W].
- `req_data`  in  NUM_REQ*DATA_W  per-unit result; unit i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  one-hot grant; combinational in the current cycle.
- `flush`  in  1  pipeline squash from ROB/branch unit.
- `cdb_valid`  out  1  registered broadcast valid.
- `cdb_tag`  out  TAG_W  registered broadcast tag.
- `cdb_data`  out  DATA_W  registered broadcast value.

## Operation
- **State**
  - `ptr`: round-robin pointer, range 0..NUM_REQ-1.
  - Output register: `cdb_valid`, `cdb_tag`, `cdb_data`.
- **Arbitration**
  - Search `req_valid` starting at index `ptr`, ascending with wrap-around.
  - The first set bit `g` wins.
  - `req_ready[g]` = 1 when `flush` = 0; all other `req_ready` bits are 0.
  - No requests, or `flush` = 1: `req_ready` = 0.
- **Handshake**
  - A transfer occurs when `req_valid[i]` and `req_ready[i]` are both 1 in the same cycle.
  - An ungranted requester must hold valid, tag and data stable until granted.
  - The arbiter never drops an accepted result, except on flush.
- **On transfer**
  - `cdb_valid` <= 1.
  - `cdb_tag`/`cdb_data` <= the winner's tag/data.
  - `ptr` <= (g+1) mod NUM_REQ.
- **No transfer**
  - `cdb_valid` <= 0.
  - `ptr` is unchanged.
  - `cdb_tag`/`cdb_data` hold their last value; don't-care while invalid.
- **Flush**
  - Forces `cdb_valid` <= 0 on the next edge.
  - Issues no grant in the flush cycle.
  - `ptr` is unchanged.
  - Requesters are expected to drop their own valids after the flush.
- **Flow**
  - No internal queue; the output register is the only buffer.
  - Sustained throughput is one result per cycle.
- **Reset**
  - `ptr` = 0, `cdb_valid` = 0, `cdb_tag` = 0, `cdb_data` = 0.
  - `req_ready` = 0 while `rst_n` = 0.
  - Reset asserted mid-broadcast clears `cdb_valid` immediately (asynchronous).

## Timing
- Latency from accept to broadcast is exactly 1 cycle: a transfer on edge N makes `cdb_valid` high during cycle N+1.
- `req_ready` is combinational from `req_valid`, `ptr`, `flush` and `rst_n`. There is no combinational path from `req_tag`/`req_data`.
- Back-to-back grants go to different units when more than one requests. A unit requesting alone is granted every cycle.
- Worst-case wait for a continuously requesting unit is NUM_REQ-1 cycles, excluding flush cycles.
- Flush has priority over a transfer in the same cycle. Flush-cycle inputs are ignored, not deferred.
- `cdb_valid` is a clean registered signal with no glitches. Consumers (RAT, reservation stations) sample it on the same edge.

## Configuration
- Macro: `CDB_ARB_PERF_EN`.
- **Defined** — adds two ports, `perf_busy_cnt` (out, 32) and `perf_conflict_cnt` (out, 32):
  - `perf_busy_cnt` increments on every transfer.
  - `perf_conflict_cnt` increments every cycle in which two or more `req_valid` bits are set and `flush` = 0.
  - Both reset to 0 on `rst_n`, are unaffected by `flush`, and wrap modulo 2^32.
- **Undefined** — the ports and counters are absent and all other behaviour is identical.

## Test plan
- **Reset:** hold `rst_n` = 0 with all `req_valid` = 1 -> `req_ready` = 0 and `cdb_valid` = 0. After release, the first grant goes to unit 0 (`ptr` = 0).
- **Single requester:** unit 2 raises valid with tag 5, data 0xDEADBEEF for one cycle -> `req_ready` = 0b0100 that cycle; next cycle `cdb_valid` = 1, `cdb_tag` = 5, `cdb_data` = 0xDEADBEEF; the cycle after, `cdb_valid` = 0.
- **Round-robin fairness:** all 4 units hold valid with tags 1..4 -> grants 0,1,2,3,0 on consecutive cycles. CDB tags 1,2,3,4 follow, one cycle later each, with `cdb_valid` continuously 1.
- **Stall hold:** units 1 and 3 request from `ptr` = 0 -> unit 1 is granted first. Unit 3 holds tag 9 stable and is granted the next cycle; `cdb_tag` = 9 on the following cycle.
- **Flush:** flush asserted in the cycle after a grant with units 0 and 1 still requesting -> `cdb_valid` = 0 the next cycle, `req_ready` = 0 during the flush cycle, and `ptr` unchanged afterwards.
- **Perf (`CDB_ARB_PERF_EN`):** 10 cycles with 3 units requesting and no flush -> `perf_busy_cnt` = 10, `perf_conflict_cnt` = 10. Then `rst_n` low -> both counters read 0.
